// File: rtl/config_pkg.sv
// Shared datapath types for the activation pipeline.
// Fixed-point format, ternary weight encoding and accumulator helpers.
package config_pkg;

  localparam int D  = 4;
  localparam int FW = 16;

  typedef logic signed [FW-1:0] fixed_point_t;
  typedef logic [$clog2(D)-1:0] DI_t;

  localparam int AW = FW + $clog2(D) + 1;
  typedef logic signed [AW-1:0] acc_t;

  typedef logic [1:0] ternary_w_t;
  localparam ternary_w_t TernZero = 2'b00;
  localparam ternary_w_t TernPos  = 2'b01;
  localparam ternary_w_t TernNeg  = 2'b11;

  localparam fixed_point_t FP_MAX = {1'b0, {(FW-1){1'b1}}};
  localparam fixed_point_t FP_MIN = {1'b1, {(FW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_WB,
    S_DONE
  } mv_state_t;

  function automatic fixed_point_t sat_to_fixed(acc_t a);
    if (a > acc_t'(FP_MAX)) return FP_MAX;
    if (a < acc_t'(FP_MIN)) return FP_MIN;
    return fixed_point_t'(a);
  endfunction

endpackage

// File: rtl/ternary_mac.sv
// Ternary multiply-accumulate lane: add, subtract or hold.
// Reserved weight code behaves as zero.
module ternary_mac
  import config_pkg::*;
(
  input  acc_t         acc,
  input  fixed_point_t x,
  input  ternary_w_t   w,
  output acc_t         acc_next
);

  always_comb begin
    acc_next = acc;
    case (w)
      TernPos: acc_next = acc + acc_t'(x);
      TernNeg: acc_next = acc - acc_t'(x);
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/ternary_matvec.sv
// Ternary matrix-vector stage: one column per cycle, one
// writeback per row, done handshake at the end of the job.
module ternary_matvec
  import config_pkg::*;
#(
  parameter int D    = config_pkg::D,
  parameter int ROWS = 2 * D
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output DI_t                        vector_r_addr_o,
  input  fixed_point_t               vector_r_data_i,
  output logic [$clog2(ROWS*D)-1:0]  weight_r_addr_o,
  input  ternary_w_t                 weight_r_data_i,
  output logic                       out_w_en_o,
  output logic [(ROWS>1 ? $clog2(ROWS) : 1)-1:0] out_w_addr_o,
  output fixed_point_t               out_w_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int WA = $clog2(ROWS*D);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;

  mv_state_t      state;
  logic [RW-1:0]  row;
  DI_t            col;
  acc_t           acc;
  acc_t           acc_next;

  ternary_mac u_mac (
    .acc      (acc),
    .x        (vector_r_data_i),
    .w        (weight_r_data_i),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            state <= S_ACCUM;
            row   <= '0;
            col   <= '0;
            acc   <= '0;
          end
        end
        S_ACCUM: begin
          acc <= acc_next;
          if (col == DI_t'(D-1)) begin
            col   <= '0;
            state <= S_WB;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_WB: begin
          acc <= '0;
          if (row == RW'(ROWS-1)) begin
            state <= S_DONE;
          end else begin
            row   <= row + 1'b1;
            state <= S_ACCUM;
          end
        end
        S_DONE: begin
          if (out_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state so reset clears them at once.
  always_comb begin
    in_ready_o      = 1'b0;
    out_valid_o     = 1'b0;
    out_w_en_o      = 1'b0;
    out_w_addr_o    = '0;
    out_w_data_o    = '0;
    vector_r_addr_o = '0;
    weight_r_addr_o = '0;
    unique case (1'b1)
      (state == S_IDLE):  in_ready_o = 1'b1;
      (state == S_ACCUM): begin
        vector_r_addr_o = col;
        weight_r_addr_o = WA'(int'(row) * D + int'(col));
      end
      (state == S_WB): begin
        out_w_en_o   = 1'b1;
        out_w_addr_o = row;
        out_w_data_o = sat_to_fixed(acc);
      end
      (state == S_DONE):  out_valid_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ternary_matvec.sv
// Randomised bench for ternary_matvec (D=4, ROWS=2) against an
// arithmetic dot-product model with clamping.
module tb_ternary_matvec;
  import config_pkg::*;

  localparam int DD = 4;
  localparam int RR = 2;
  localparam int SENT = -100000;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         out_ready_i = 1'b0;
  logic         in_ready_o;
  DI_t          vector_r_addr_o;
  fixed_point_t vector_r_data_i;
  logic [2:0]   weight_r_addr_o;
  ternary_w_t   weight_r_data_i;
  logic         out_w_en_o;
  logic [0:0]   out_w_addr_o;
  fixed_point_t out_w_data_o;
  logic         out_valid_o;

  fixed_point_t vec[DD];
  ternary_w_t   wm[RR*DD];
  int           obuf[RR];
  int           nwr;
  int           errors = 0;
  int           checks = 0;

  assign vector_r_data_i = vec[vector_r_addr_o];
  assign weight_r_data_i = wm[weight_r_addr_o];

  ternary_matvec #(.D(DD), .ROWS(RR)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .vector_r_addr_o (vector_r_addr_o),
    .vector_r_data_i (vector_r_data_i),
    .weight_r_addr_o (weight_r_addr_o),
    .weight_r_data_i (weight_r_data_i),
    .out_w_en_o      (out_w_en_o),
    .out_w_addr_o    (out_w_addr_o),
    .out_w_data_o    (out_w_data_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_row(int r);
    int s = 0;
    for (int c = 0; c < DD; c++) begin
      if (wm[r*DD+c] == 2'b01) s += int'(vec[c]);
      else if (wm[r*DD+c] == 2'b11) s -= int'(vec[c]);
    end
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic clear_obuf();
    for (int r = 0; r < RR; r++) obuf[r] = SENT;
    nwr = 0;
  endtask

  task automatic tick_log();
    if (out_w_en_o) begin
      obuf[out_w_addr_o] = int'(out_w_data_o);
      nwr++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job();
    in_valid_i = 1'b1;
    tick_log();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int fw, output int dv);
    fw = -1;
    dv = -1;
    for (int k = 1; k <= 60; k++) begin
      if (out_w_en_o && fw < 0) fw = k;
      if (out_valid_o) begin
        dv = k;
        break;
      end
      tick_log();
    end
  endtask

  task automatic check_rows(string tag);
    for (int r = 0; r < RR; r++)
      check($sformatf("%s_row%0d", tag, r), obuf[r], model_row(r));
    check({tag, "_nwr"}, nwr, RR);
  endtask

  task automatic ack();
    out_ready_i = 1'b1;
    tick_log();
    check("ack_idle", int'(in_ready_o), 1);
    out_ready_i = 1'b0;
  endtask

  task automatic rand_pattern();
    for (int c = 0; c < DD; c++) vec[c] = fixed_point_t'($urandom);
    for (int i = 0; i < RR*DD; i++)
      wm[i] = ternary_w_t'($urandom_range(0, 3));
  endtask

  initial begin
    int fw, dv, bad;

    #2;
    check("rst_in_ready", int'(in_ready_o), 1);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_w_en", int'(out_w_en_o), 0);
    check("rst_waddr", int'(weight_r_addr_o), 0);
    check("rst_wdata", int'(out_w_data_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick_log();

    // Basic job
    vec[0] = 1; vec[1] = 2; vec[2] = 3; vec[3] = 4;
    for (int c = 0; c < DD; c++) wm[c] = 2'b01;
    wm[4] = 2'b11; wm[5] = 2'b00; wm[6] = 2'b01; wm[7] = 2'b10;
    clear_obuf();
    start_job();
    wait_done(fw, dv);
    check("basic_first_wr", fw, 5);
    check("basic_done", dv, 11);
    check("basic_row0_const", obuf[0], 10);
    check("basic_row1_const", obuf[1], 2);
    check_rows("basic");
    check("excl_ready", int'(in_ready_o), 0);

    // Done held without acknowledge
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || out_w_en_o !== 1'b0)
        bad++;
      tick_log();
    end
    check("hold_bad_cycles", bad, 0);
    check("hold_nwr", nwr, RR);
    ack();

    // Saturation both directions
    for (int c = 0; c < DD; c++) begin
      vec[c] = 16'sh7fff;
      wm[c] = 2'b01;
      wm[DD+c] = 2'b11;
    end
    clear_obuf();
    start_job();
    wait_done(fw, dv);
    check("sat_pos", obuf[0], 32767);
    check("sat_neg", obuf[1], -32768);
    check_rows("sat");
    ack();

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      rand_pattern();
      clear_obuf();
      start_job();
      wait_done(fw, dv);
      check($sformatf("rnd%0d_first_wr", j), fw, 5);
      check($sformatf("rnd%0d_done", j), dv, 11);
      check_rows($sformatf("rnd%0d", j));
      repeat ($urandom_range(0, 3)) tick_log();
      ack();
    end

    // Back-to-back jobs with in_valid held
    rand_pattern();
    clear_obuf();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1;
    tick_log();
    wait_done(fw, dv);
    check("b2b_done1", dv, 11);
    check_rows("b2b1");
    tick_log();
    check("b2b_idle", int'(in_ready_o), 1);
    clear_obuf();
    tick_log();
    check("b2b_restart", int'(in_ready_o), 0);
    in_valid_i = 1'b0;
    wait_done(fw, dv);
    check("b2b_first_wr2", fw, 5);
    check("b2b_done2", dv, 11);
    check_rows("b2b2");
    tick_log();
    check("b2b_final_idle", int'(in_ready_o), 1);
    out_ready_i = 1'b0;

    // Start pulse while busy is ignored
    rand_pattern();
    clear_obuf();
    start_job();
    tick_log();
    tick_log();
    in_valid_i = 1'b1;
    tick_log();
    in_valid_i = 1'b0;
    wait_done(fw, dv);
    check("busy_first_wr", fw, 2);
    check("busy_done", dv, 8);
    check_rows("busy");
    ack();

    // Reset during row1, col2
    rand_pattern();
    clear_obuf();
    start_job();
    repeat (7) tick_log();
    check("mid_waddr", int'(weight_r_addr_o), 6);
    check("mid_vaddr", int'(vector_r_addr_o), 2);
    rst_ni = 1'b0;
    #1;
    check("arst_in_ready", int'(in_ready_o), 1);
    check("arst_out_valid", int'(out_valid_o), 0);
    check("arst_w_en", int'(out_w_en_o), 0);
    check("arst_waddr", int'(weight_r_addr_o), 0);
    check("arst_vaddr", int'(vector_r_addr_o), 0);
    check("arst_nwr", nwr, 1);
    check("arst_row0", obuf[0], model_row(0));
    check("arst_row1", obuf[1], SENT);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick_log();
    clear_obuf();
    start_job();
    wait_done(fw, dv);
    check("rerun_first_wr", fw, 5);
    check("rerun_done", dv, 11);
    check_rows("rerun");
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
